// File: rtl/load_unit_pkg.sv
// Shared constants and types for the load unit: opcode, load subtypes,
// FSM state encoding and the alignment/legality check.
package load_unit_pkg;

    localparam logic [6:0] loadOp     = 7'b0000011;
    localparam logic [5:0] invalidNum = 6'b010000;

    localparam logic [2:0] TYPE_LB  = 3'b000;
    localparam logic [2:0] TYPE_LH  = 3'b001;
    localparam logic [2:0] TYPE_LW  = 3'b010;
    localparam logic [2:0] TYPE_LBU = 3'b100;
    localparam logic [2:0] TYPE_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CAST  = 2'd2,
        DRAIN = 2'd3
    } load_state_e;

    // Returns 1 for a misaligned access or an undefined subtype; such loads
    // broadcast an exception without touching memory.
    function automatic logic load_fault(input logic [2:0] load_type, input logic [1:0] lo);
        logic fault;
        fault = 1'b0;
        case (load_type)
            TYPE_LB, TYPE_LBU: fault = 1'b0;
            TYPE_LH, TYPE_LHU: fault = lo[0];
            TYPE_LW:           fault = (lo != 2'b00);
            default:           fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/load_req_fifo.sv
// Request buffer for the load unit: power-of-two circular FIFO with
// simultaneous push/pop and a synchronous clear used for pipeline flush.
module load_req_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 41
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: buffers load requests, issues one word read at a time, formats
// the returned data and broadcasts it on the CDB in acceptance order.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_W      = 6
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          loadEnable,
    input  logic [ROB_W-1:0]              robNum_in,
    input  logic [2:0]                    type_in,
    input  logic [31:0]                   addr_in,
    output logic                          busy,
    input  logic                          flush,
    output logic                          memReadEnable,
    output logic [31:0]                   memAddr,
    input  logic                          memReady,
    input  logic [31:0]                   memData,
    output logic                          cdbIscast,
    output logic [31:0]                   cdbData,
    output logic [ROB_W-1:0]              cdbRobNum,
    output logic                          cdbExcp,
    input  logic                          cdbGrant,
    output load_state_e                   dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]   dbg_count
);
    localparam int REQ_W = ROB_W + 3 + 32;

    load_state_e             state;
    logic [2:0]              cur_type;
    logic [1:0]              cur_lo;

    logic                    push_ok;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [REQ_W-1:0]        in_req;
    logic [REQ_W-1:0]        fifo_dout;
    logic [REQ_W-1:0]        head;
    logic                    head_valid;
    logic [ROB_W-1:0]        head_rob;
    logic [2:0]              head_type;
    logic [31:0]             head_addr;

    function automatic logic [31:0] format_load(input logic [2:0]  load_type,
                                                input logic [1:0]  lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*lo +: 8];
        h = word[16*lo[1] +: 16];
        case (load_type)
            TYPE_LB:  r = {{24{b[7]}}, b};
            TYPE_LH:  r = {{16{h[15]}}, h};
            TYPE_LW:  r = word;
            TYPE_LBU: r = {24'h0, b};
            TYPE_LHU: r = {16'h0, h};
            default:  r = 32'h0;
        endcase
        return r;
    endfunction

    assign busy      = fifo_full || (state == DRAIN);
    assign push_ok   = loadEnable && !busy && !flush;
    assign in_req    = {robNum_in, type_in, addr_in};

    // With an empty buffer in IDLE the incoming request bypasses the FIFO so a
    // load reaches memory one edge after it is accepted.
    assign fifo_push  = push_ok && !((state == IDLE) && fifo_empty);
    assign fifo_pop   = (state == IDLE) && !fifo_empty && !flush;
    assign head       = fifo_empty ? in_req : fifo_dout;
    assign head_valid = (state == IDLE) && (!fifo_empty || push_ok) && !flush;
    assign head_rob   = head[REQ_W-1 -: ROB_W];
    assign head_type  = head[34:32];
    assign head_addr  = head[31:0];

    assign dbg_state  = state;

    load_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REQ_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_req),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (dbg_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cur_type      <= 3'b000;
            cur_lo        <= 2'b00;
            memReadEnable <= 1'b0;
            memAddr       <= 32'h0;
            cdbIscast     <= 1'b0;
            cdbData       <= 32'h0;
            cdbRobNum     <= '0;
            cdbExcp       <= 1'b0;
        end else begin
            memReadEnable <= 1'b0;
            case (state)
                IDLE: begin
                    if (head_valid) begin
                        cdbRobNum <= head_rob;
                        cur_type  <= head_type;
                        cur_lo    <= head_addr[1:0];
                        if (load_fault(head_type, head_addr[1:0])) begin
                            cdbData   <= 32'h0;
                            cdbExcp   <= 1'b1;
                            cdbIscast <= 1'b1;
                            state     <= CAST;
                        end else begin
                            memReadEnable <= 1'b1;
                            memAddr       <= {head_addr[31:2], 2'b00};
                            state         <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A flush that coincides with the data closes the read.
                    if (flush) begin
                        state <= memReady ? IDLE : DRAIN;
                    end else if (memReady) begin
                        cdbData   <= format_load(cur_type, cur_lo, memData);
                        cdbExcp   <= 1'b0;
                        cdbIscast <= 1'b1;
                        state     <= CAST;
                    end
                end
                CAST: begin
                    if (flush || cdbGrant) begin
                        cdbIscast <= 1'b0;
                        state     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (memReady) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: formatting, exceptions, ordering under
// back-pressure, flush/drain, grant stall and reset behaviour.
module tb_load_unit;
    import load_unit_pkg::*;

    localparam int FIFO_DEPTH = 2;
    localparam int ROB_W      = 6;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              loadEnable;
    logic [ROB_W-1:0]  robNum_in;
    logic [2:0]        type_in;
    logic [31:0]       addr_in;
    logic              busy;
    logic              flush;
    logic              memReadEnable;
    logic [31:0]       memAddr;
    logic              memReady;
    logic [31:0]       memData;
    logic              cdbIscast;
    logic [31:0]       cdbData;
    logic [ROB_W-1:0]  cdbRobNum;
    logic              cdbExcp;
    logic              cdbGrant;
    load_state_e       dbg_state;
    logic [CNT_W-1:0]  dbg_count;

    int checks = 0;
    int errors = 0;
    int rd_total = 0;
    int bc_total = 0;

    logic [ROB_W-1:0] exp_q[$];
    logic [31:0]      exp_addr_q[$];

    load_unit #(.FIFO_DEPTH(FIFO_DEPTH), .ROB_W(ROB_W)) dut (
        .clock(clock), .reset(reset), .loadEnable(loadEnable), .robNum_in(robNum_in),
        .type_in(type_in), .addr_in(addr_in), .busy(busy), .flush(flush),
        .memReadEnable(memReadEnable), .memAddr(memAddr), .memReady(memReady),
        .memData(memData), .cdbIscast(cdbIscast), .cdbData(cdbData),
        .cdbRobNum(cdbRobNum), .cdbExcp(cdbExcp), .cdbGrant(cdbGrant),
        .dbg_state(dbg_state), .dbg_count(dbg_count)
    );

    // clock / reset
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (memReadEnable) rd_total++;
        if (cdbIscast && cdbGrant) bc_total++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [ROB_W-1:0] rob, input logic [2:0] t, input logic [31:0] a);
        loadEnable = 1'b1;
        robNum_in  = rob;
        type_in    = t;
        addr_in    = a;
        tick();
        loadEnable = 1'b0;
    endtask

    task automatic grant_once();
        cdbGrant = 1'b1;
        tick();
        cdbGrant = 1'b0;
    endtask

    task automatic wait_read(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (memReadEnable) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; loadEnable = 1'b0; robNum_in = '0; type_in = 3'b0; addr_in = 32'h0;
        flush = 1'b0; memReady = 1'b0; memData = 32'h0; cdbGrant = 1'b0;
        #2;
        checks++; if ({busy, memReadEnable, cdbIscast, cdbExcp} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b expected 0000", {busy, memReadEnable, cdbIscast, cdbExcp}); end
        checks++; if (memAddr !== 32'h0) begin errors++; $display("FAIL reset_memAddr got %h expected 0", memAddr); end
        checks++; if (cdbData !== 32'h0) begin errors++; $display("FAIL reset_cdbData got %h expected 0", cdbData); end
        checks++; if (cdbRobNum !== '0) begin errors++; $display("FAIL reset_cdbRobNum got %h expected 0", cdbRobNum); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d expected IDLE", dbg_state); end
        loadEnable = 1'b1; type_in = TYPE_LW; addr_in = 32'h40;
        tick();
        loadEnable = 1'b0;
        checks++; if (dbg_count !== '0 || memReadEnable !== 1'b0) begin
            errors++; $display("FAIL reset_ignore_load got count %0d rd %b expected 0 0", dbg_count, memReadEnable); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lb();
        issue(6'd5, TYPE_LB, 32'h103);
        checks++; if (memReadEnable !== 1'b1) begin errors++; $display("FAIL lb_read got %b expected 1", memReadEnable); end
        checks++; if (memAddr !== 32'h100) begin errors++; $display("FAIL lb_memAddr got %h expected 00000100", memAddr); end
        tick();
        checks++; if (memReadEnable !== 1'b0) begin errors++; $display("FAIL lb_strobe_len got %b expected 0", memReadEnable); end
        memReady = 1'b1; memData = 32'h80FF1234;
        tick();
        memReady = 1'b0;
        checks++; if (cdbIscast !== 1'b1) begin errors++; $display("FAIL lb_cast got %b expected 1", cdbIscast); end
        checks++; if (cdbData !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h expected ffffff80", cdbData); end
        checks++; if (cdbRobNum !== 6'd5 || cdbExcp !== 1'b0) begin
            errors++; $display("FAIL lb_tag_excp got %0d/%b expected 5/0", cdbRobNum, cdbExcp); end
        grant_once();
        checks++; if (cdbIscast !== 1'b0) begin errors++; $display("FAIL lb_release got %b expected 0", cdbIscast); end
    endtask

    task automatic test_half();
        logic [2:0]  types [2];
        logic [31:0] exps  [2];
        types[0] = TYPE_LHU; exps[0] = 32'h0000BEEF;
        types[1] = TYPE_LH;  exps[1] = 32'hFFFFBEEF;
        for (int i = 0; i < 2; i++) begin
            issue(6'(12 + i), types[i], 32'h102);
            checks++; if (memReadEnable !== 1'b1 || memAddr !== 32'h100) begin
                errors++; $display("FAIL half_read[%0d] got %b/%h expected 1/00000100", i, memReadEnable, memAddr); end
            memReady = 1'b1; memData = 32'hBEEF0000;
            tick();
            memReady = 1'b0;
            checks++; if (cdbIscast !== 1'b1 || cdbData !== exps[i]) begin
                errors++; $display("FAIL half_data[%0d] got %b/%h expected 1/%h", i, cdbIscast, cdbData, exps[i]); end
            grant_once();
        end
    endtask

    task automatic test_misaligned();
        int rd0;
        rd0 = rd_total;
        issue(6'd9, TYPE_LW, 32'h101);
        checks++; if (memReadEnable !== 1'b0) begin errors++; $display("FAIL mis_no_read got %b expected 0", memReadEnable); end
        checks++; if (cdbIscast !== 1'b1 || cdbExcp !== 1'b1) begin
            errors++; $display("FAIL mis_cast got %b/%b expected 1/1", cdbIscast, cdbExcp); end
        checks++; if (cdbData !== 32'h0 || cdbRobNum !== 6'd9) begin
            errors++; $display("FAIL mis_payload got %h/%0d expected 0/9", cdbData, cdbRobNum); end
        grant_once();
        issue(6'd10, 3'b111, 32'h100);
        checks++; if (cdbIscast !== 1'b1 || cdbExcp !== 1'b1 || cdbRobNum !== 6'd10) begin
            errors++; $display("FAIL illegal_cast got %b/%b/%0d expected 1/1/10", cdbIscast, cdbExcp, cdbRobNum); end
        grant_once();
        checks++; if (rd_total != rd0) begin errors++; $display("FAIL mis_reads got %0d expected %0d", rd_total, rd0); end
    endtask

    task automatic test_back_to_back();
        int rd0, bc0;
        bit ok;
        logic [31:0] a;
        rd0 = rd_total; bc0 = bc_total;
        issue(6'd1, TYPE_LW, 32'h200); exp_q.push_back(6'd1); exp_addr_q.push_back(32'h200);
        checks++; if (memReadEnable !== 1'b1) begin errors++; $display("FAIL b2b_first_read got %b expected 1", memReadEnable); end
        issue(6'd2, TYPE_LW, 32'h204); exp_q.push_back(6'd2); exp_addr_q.push_back(32'h204);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_not_busy got %b expected 0", busy); end
        issue(6'd3, TYPE_LW, 32'h208); exp_q.push_back(6'd3); exp_addr_q.push_back(32'h208);
        checks++; if (busy !== 1'b1 || dbg_count !== 2'd2) begin
            errors++; $display("FAIL b2b_full got %b/%0d expected 1/2", busy, dbg_count); end
        issue(6'd4, TYPE_LW, 32'h20C);
        checks++; if (dbg_count !== 2'd2) begin errors++; $display("FAIL b2b_drop got %0d expected 2", dbg_count); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                wait_read(ok);
                checks++; if (!ok) begin errors++; $display("FAIL b2b_read_timeout[%0d] got none expected read", i); end
            end
            a = exp_addr_q.pop_front();
            checks++; if (memAddr !== a) begin errors++; $display("FAIL b2b_addr[%0d] got %h expected %h", i, memAddr, a); end
            repeat (5) tick();
            memReady = 1'b1; memData = 32'hD0000000 | a;
            tick();
            memReady = 1'b0;
            checks++; if (cdbIscast !== 1'b1 || cdbRobNum !== exp_q[0]) begin
                errors++; $display("FAIL b2b_order[%0d] got %b/%0d expected 1/%0d", i, cdbIscast, cdbRobNum, exp_q[0]); end
            void'(exp_q.pop_front());
            checks++; if (cdbData !== (32'hD0000000 | a)) begin
                errors++; $display("FAIL b2b_data[%0d] got %h expected %h", i, cdbData, 32'hD0000000 | a); end
            grant_once();
        end
        repeat (6) tick();
        checks++; if (rd_total - rd0 != 3 || bc_total - bc0 != 3) begin
            errors++; $display("FAIL b2b_counts got rd %0d bc %0d expected 3 3", rd_total - rd0, bc_total - bc0); end
        checks++; if (dbg_count !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_empty got %0d/%b expected 0/0", dbg_count, busy); end
    endtask

    task automatic test_flush();
        int bc0;
        bc0 = bc_total;
        issue(6'd7, TYPE_LW, 32'h300);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (dbg_state !== DRAIN || busy !== 1'b1) begin
            errors++; $display("FAIL flush_drain got %0d/%b expected DRAIN/1", dbg_state, busy); end
        issue(6'd6, TYPE_LW, 32'h500);
        checks++; if (dbg_count !== '0 || busy !== 1'b1) begin
            errors++; $display("FAIL drain_drop got %0d/%b expected 0/1", dbg_count, busy); end
        tick();
        memReady = 1'b1; memData = 32'hCAFEF00D;
        tick();
        memReady = 1'b0;
        checks++; if (dbg_state !== IDLE || busy !== 1'b0 || cdbIscast !== 1'b0) begin
            errors++; $display("FAIL drain_exit got %0d/%b/%b expected IDLE/0/0", dbg_state, busy, cdbIscast); end
        issue(6'd8, TYPE_LW, 32'h400);
        checks++; if (memReadEnable !== 1'b1 || memAddr !== 32'h400) begin
            errors++; $display("FAIL after_drain_read got %b/%h expected 1/00000400", memReadEnable, memAddr); end
        memReady = 1'b1; memData = 32'h12345678;
        tick();
        memReady = 1'b0;
        checks++; if (cdbIscast !== 1'b1 || cdbRobNum !== 6'd8 || cdbData !== 32'h12345678) begin
            errors++; $display("FAIL after_drain_cast got %b/%0d/%h expected 1/8/12345678", cdbIscast, cdbRobNum, cdbData); end
        grant_once();
        issue(6'd20, TYPE_LW, 32'h600);
        flush = 1'b1; memReady = 1'b1;
        tick();
        flush = 1'b0; memReady = 1'b0;
        checks++; if (dbg_state !== IDLE || cdbIscast !== 1'b0) begin
            errors++; $display("FAIL flush_ready got %0d/%b expected IDLE/0", dbg_state, cdbIscast); end
        issue(6'd21, TYPE_LW, 32'h101);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (dbg_state !== IDLE || cdbIscast !== 1'b0) begin
            errors++; $display("FAIL flush_cast got %0d/%b expected IDLE/0", dbg_state, cdbIscast); end
        flush = 1'b1;
        issue(6'd22, TYPE_LW, 32'h700);
        flush = 1'b0;
        checks++; if (memReadEnable !== 1'b0 || dbg_count !== '0) begin
            errors++; $display("FAIL flush_drop_load got %b/%0d expected 0/0", memReadEnable, dbg_count); end
        checks++; if (bc_total - bc0 != 1) begin errors++; $display("FAIL flush_bcasts got %0d expected 1", bc_total - bc0); end
    endtask

    task automatic test_grant_stall();
        int bc0;
        bc0 = bc_total;
        issue(6'd11, TYPE_LBU, 32'h001);
        memReady = 1'b1; memData = 32'h0000AB00;
        tick();
        memReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (cdbIscast !== 1'b1 || cdbData !== 32'h000000AB || cdbRobNum !== 6'd11) begin
                errors++; $display("FAIL stall_hold[%0d] got %b/%h/%0d expected 1/000000ab/11", i, cdbIscast, cdbData, cdbRobNum); end
            if (i == 1) begin memReady = 1'b1; memData = 32'h55555555; end
            tick();
            memReady = 1'b0;
        end
        grant_once();
        checks++; if (cdbIscast !== 1'b0 || bc_total - bc0 != 1) begin
            errors++; $display("FAIL stall_release got %b/%0d expected 0/1", cdbIscast, bc_total - bc0); end
    endtask

    task automatic test_reset_wait();
        issue(6'd30, TYPE_LW, 32'h700);
        reset = 1'b1;
        #1;
        checks++; if (memReadEnable !== 1'b0 || dbg_state !== IDLE) begin
            errors++; $display("FAIL async_reset got %b/%0d expected 0/IDLE", memReadEnable, dbg_state); end
        #1 reset = 1'b0;
        memReady = 1'b1; memData = 32'h87654321;
        tick();
        memReady = 1'b0;
        tick();
        checks++; if (cdbIscast !== 1'b0 || dbg_state !== IDLE) begin
            errors++; $display("FAIL reset_stale_ready got %b/%0d expected 0/IDLE", cdbIscast, dbg_state); end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_half();
        test_misaligned();
        test_back_to_back();
        test_flush();
        test_grant_stall();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
